// File: rtl/lcd_result_sequencer.sv
// rtl/lcd_result_sequencer.sv - sequences LCD power-up commands and "A op B=R1R2" line refreshes
// Single FSM drives the lcd handshake (iDATA/iRS/iStart/oDone) with registered outputs.
module lcd_result_sequencer #(
    parameter int DLY_CYCLES = 262142
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iUpdate,
    input  logic [7:0] iA,
    input  logic [7:0] iB,
    input  logic [1:0] iOp,
    input  logic [7:0] iRes1,
    input  logic [7:0] iRes2,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone,
    output logic       oBusy,
    output logic       oReady
);

    localparam int CW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
    localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYCLES - 1);
    localparam logic [2:0] INIT_LAST = 3'd4;
    localparam logic [2:0] REF_LAST  = 3'd6;

    typedef enum logic [3:0] {
        INIT_SEND,
        INIT_WAIT_LO,
        INIT_WAIT_HI,
        INIT_DLY,
        IDLE,
        REF_SNAP,
        REF_SEND,
        REF_WAIT_LO,
        REF_WAIT_HI,
        REF_DLY
    } state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [CW-1:0]   dly_cnt;
    logic            pending;
    logic [7:0]      snap_a;
    logic [7:0]      snap_b;
    logic [1:0]      snap_op;
    logic [7:0]      snap_r1;
    logic [7:0]      snap_r2;
    logic [7:0]      init_byte;
    logic [7:0]      ref_byte;
    logic            dly_done;

    function automatic logic [7:0] dig(input logic [7:0] v);
        return (v > 8'd9) ? 8'h3F : (8'h30 + v);
    endfunction

    function automatic logic [7:0] opc(input logic [1:0] op);
        case (op)
            2'd0:    return 8'h2B;
            2'd1:    return 8'h2D;
            2'd2:    return 8'h2A;
            default: return 8'h2F;
        endcase
    endfunction

    always_comb begin
        init_byte = 8'h80;
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h80;
        endcase
    end

    // Refresh bytes come only from the snapshot so mid-refresh input changes cannot tear the line.
    always_comb begin
        ref_byte = 8'h80;
        case (idx)
            3'd1:    ref_byte = dig(snap_a);
            3'd2:    ref_byte = opc(snap_op);
            3'd3:    ref_byte = dig(snap_b);
            3'd4:    ref_byte = 8'h3D;
            3'd5:    ref_byte = dig(snap_r1);
            3'd6:    ref_byte = dig(snap_r2);
            default: ref_byte = 8'h80;
        endcase
    end

    assign dly_done = (dly_cnt == DLY_LAST);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= INIT_SEND;
            idx     <= 3'd0;
            dly_cnt <= '0;
            pending <= 1'b0;
            snap_a  <= 8'd0;
            snap_b  <= 8'd0;
            snap_op <= 2'd0;
            snap_r1 <= 8'd0;
            snap_r2 <= 8'd0;
            oDATA   <= 8'd0;
            oRS     <= 1'b0;
            oStart  <= 1'b0;
            oBusy   <= 1'b1;
            oReady  <= 1'b0;
        end else begin
            // Any request arriving outside IDLE/SNAP collapses into a single queued refresh.
            if (iUpdate && state != IDLE && state != REF_SNAP) begin
                pending <= 1'b1;
            end

            case (state)
                INIT_SEND: begin
                    oDATA  <= init_byte;
                    oRS    <= 1'b0;
                    oStart <= 1'b1;
                    state  <= INIT_WAIT_LO;
                end
                INIT_WAIT_LO: begin
                    oStart <= 1'b0;
                    if (!iDone) begin
                        state <= INIT_WAIT_HI;
                    end
                end
                INIT_WAIT_HI: begin
                    if (iDone) begin
                        dly_cnt <= '0;
                        state   <= INIT_DLY;
                    end
                end
                INIT_DLY: begin
                    if (dly_done) begin
                        dly_cnt <= '0;
                        if (idx == INIT_LAST) begin
                            idx    <= 3'd0;
                            oReady <= 1'b1;
                            oBusy  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= INIT_SEND;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (pending || iUpdate) begin
                        state <= REF_SNAP;
                    end
                end
                REF_SNAP: begin
                    snap_a  <= iA;
                    snap_b  <= iB;
                    snap_op <= iOp;
                    snap_r1 <= iRes1;
                    snap_r2 <= iRes2;
                    pending <= 1'b0;
                    oBusy   <= 1'b1;
                    idx     <= 3'd0;
                    state   <= REF_SEND;
                end
                REF_SEND: begin
                    oDATA  <= ref_byte;
                    oRS    <= (idx != 3'd0);
                    oStart <= 1'b1;
                    state  <= REF_WAIT_LO;
                end
                REF_WAIT_LO: begin
                    oStart <= 1'b0;
                    if (!iDone) begin
                        state <= REF_WAIT_HI;
                    end
                end
                REF_WAIT_HI: begin
                    if (iDone) begin
                        dly_cnt <= '0;
                        state   <= REF_DLY;
                    end
                end
                REF_DLY: begin
                    if (dly_done) begin
                        dly_cnt <= '0;
                        if (idx == REF_LAST) begin
                            idx   <= 3'd0;
                            oBusy <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= REF_SEND;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= INIT_SEND;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_result_sequencer.md
Name: lcd_result_sequencer

Overview:
- Drives the character-LCD controller (`lcd`, handshake `iDATA`/`iRS`/`iStart`/`oDone`) from a single clocked FSM.
- After reset it sends the LCD power-up command sequence.
- After that, on each refresh request, it writes the ULA expression "A op B=R1R2" on line 1.
- It replaces the ad-hoc, key-clocked LCD writes in `control_unit`. It sits between the ULA/operand registers and the `lcd` instance.

Parameters:
- DLY_CYCLES, 262142 (18'h3FFFE): idle cycles inserted after each completed LCD transfer. Minimum legal value is 1.

Ports:
- iCLK  in  1  system clock (CLOCK_50)
- iRST_N  in  1  asynchronous active-low reset (from Reset_Delay)
- iUpdate  in  1  refresh request; level sampled each cycle, a one-cycle pulse is sufficient
- iA  in  8  operand A (binary)
- iB  in  8  operand B (binary)
- iOp  in  2  operation code: 0 sum, 1 sub, 2 mult, 3 div
- iRes1  in  8  ULA result1
- iRes2  in  8  ULA result2
- oDATA  out  8  byte to lcd.iDATA
- oRS  out  1  to lcd.iRS (0 = command, 1 = character)
- oStart  out  1  to lcd.iStart
- iDone  in  1  from lcd.oDone
- oBusy  out  1  high while any transfer sequence (init or refresh) is in progress
- oReady  out  1  high once the init sequence has completed; stays high until reset

Behaviour:
- Reset (async, iRST_N=0):
  - oDATA=0, oRS=0, oStart=0, oBusy=1, oReady=0.
  - pending=0, entry index=0, delay counter=0, state=INIT_SEND.
  - Reset asserted at any point aborts the current transfer; the init sequence restarts from entry 0 on release.
- Init table (all RS=0), in order: 0x38, 0x0C, 0x01, 0x06, 0x80.
- Refresh table, 7 entries, in order:
  - 0x80, RS=0 (cursor to line 1, column 0)
  - dig(A), RS=1
  - opc(Op), RS=1
  - dig(B), RS=1
  - 0x3D '=', RS=1
  - dig(R1), RS=1
  - dig(R2), RS=1
- dig(v): 0x30+v for v in 0..9; 0x3F '?' for v>9. Full 8-bit compare.
- opc: 0→0x2B '+', 1→0x2D '-', 2→0x2A '*', 3→0x2F '/'.
- Per-entry transfer, identical for both tables:
  - SEND: oDATA/oRS drive the table entry and oStart=1 for exactly one cycle. Next state is WAIT_LO.
  - WAIT_LO: oStart=0. Wait until iDone=0 is sampled; this rejects a stale oDone left high from the previous transfer. Then go to WAIT_HI.
  - WAIT_HI: wait until iDone=1, then go to DLY.
  - DLY: count 0..DLY_CYCLES-1. On the terminal count:
    - if more entries remain: index+1, go to SEND;
    - otherwise the sequence ends.
  - oDATA/oRS hold their value from SEND until the next SEND.
- States: INIT_SEND/INIT_WAIT_LO/INIT_WAIT_HI/INIT_DLY → IDLE, then REF_SNAP → REF_SEND/REF_WAIT_LO/REF_WAIT_HI/REF_DLY → IDLE.
  - End of the init sequence: oReady←1 in the same edge that enters IDLE.
  - IDLE: oBusy=0. If pending=1 or iUpdate=1, go to REF_SNAP.
  - REF_SNAP (1 cycle): latch iA, iB, iOp, iRes1, iRes2 into snapshot registers, clear pending, set oBusy=1, index=0.
  - The refresh table is built from the snapshot only; input changes mid-refresh do not affect the displayed line.
- Request handling:
  - iUpdate high while oBusy=1 sets pending=1. At most one request is queued; further requests collapse into it.
  - iUpdate during init is also queued, so the first refresh follows init automatically.
  - iUpdate in the same cycle the last entry's DLY ends is queued, not lost.
- Latency:
  - Each entry takes 1 (SEND) + LCD handshake + DLY_CYCLES cycles.
  - A request in IDLE gives oStart high 2 cycles later (REF_SNAP, then REF_SEND).

Test Plan:
- Release reset, DLY_CYCLES=4, lcd model answers iDone 3 cycles after oStart → oStart pulses carry 0x38, 0x0C, 0x01, 0x06, 0x80 with RS=0. Consecutive pulses are ≥8 cycles apart. oReady rises after the 5th delay; oBusy then falls.
- A=3, B=4, Op=2, R1=1, R2=2, single iUpdate pulse in IDLE → bytes 0x80 (RS0), then 0x33, 0x2A, 0x34, 0x3D, 0x31, 0x32 (RS1). oBusy falls after the last delay.
- A=12, Op=3, R2=255 → A, R2 display 0x3F; Op displays 0x2F.
- Three iUpdate pulses during a refresh, with A changed to 7 mid-refresh → current line unchanged. Exactly one further refresh follows, and it shows 0x37.
- iDone held high (stale) before oStart → no advance until iDone goes low then high.
- Assert iRST_N=0 during refresh entry 4 → outputs at reset values immediately (oStart=0, oReady=0). After release the init sequence restarts at 0x38.
